ranc_tick_scheduler: RTL and testbench

Run controller that sequences the RANC network over a multi-tick inference. It sits between the host control registers and the `tick` input shared by the AXIS slave, PacketFetch, input buffer and network grid. Each tick is issued only when the host has staged that tick's input packets, the input buffer has drained, and the minimum tick period has elapsed. It counts ticks and output spikes per run and flags stalls.

---
 rtl/ranc_ctrl_pkg.sv | 20 ++
 rtl/ranc_period_timer.sv | 31 +++
 rtl/ranc_tick_scheduler.sv | 165 ++++++++++++++++
 tb/tb_ranc_tick_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ranc_ctrl_pkg.sv
// Shared definitions for the RANC run controller: state encoding and default widths.
package ranc_ctrl_pkg;

  localparam int TICK_CNT_WIDTH_DEF  = 16;
  localparam int PERIOD_WIDTH_DEF    = 20;
  localparam int SPIKE_CNT_WIDTH_DEF = 16;

  // Shortest legal spacing between tick pulses, in cycles.
  localparam int MIN_PERIOD = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INPUT,
    ST_DRAIN,
    ST_TICK,
    ST_GAP,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/ranc_period_timer.sv
// Loadable saturating down-counter. 'expired' is high while the count sits at zero.
// Used both as the tick-period timer and as the stall watchdog.
module ranc_period_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down while enabled and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ranc_tick_scheduler.sv
// Run controller for a multi-tick RANC inference: gates each network tick on staged
// input, a drained input buffer and the minimum tick period; counts ticks and spikes,
// and flags a stall when the host or buffer stops making progress.
module ranc_tick_scheduler import ranc_ctrl_pkg::*; #(
  parameter int TICK_CNT_WIDTH  = TICK_CNT_WIDTH_DEF,
  parameter int PERIOD_WIDTH    = PERIOD_WIDTH_DEF,
  parameter int SPIKE_CNT_WIDTH = SPIKE_CNT_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [TICK_CNT_WIDTH-1:0]  num_ticks,
  input  logic [PERIOD_WIDTH-1:0]    tick_period,
  input  logic                       input_ready,
  input  logic                       buffer_empty,
  input  logic                       packet_out_valid,
  output logic                       tick,
  output logic                       busy,
  output logic                       done,
  output logic [TICK_CNT_WIDTH-1:0]  tick_count,
  output logic [SPIKE_CNT_WIDTH-1:0] spike_count,
  output logic                       stall_error
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                     state_q, state_d;
  logic [TICK_CNT_WIDTH-1:0]  nt_q, nt_d;
  logic [PERIOD_WIDTH-1:0]    per_q, per_d;
  logic [TICK_CNT_WIDTH-1:0]  tcnt_q, tcnt_d;
  logic [SPIKE_CNT_WIDTH-1:0] scnt_q, scnt_d;
  logic                       stall_q, stall_d;
  logic                       tick_q, tick_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       start_ok;
  logic                       stall_set;
  logic                       in_wait;
  logic [PERIOD_WIDTH-1:0]    per_clamped;
  logic                       per_load;
  logic [PERIOD_WIDTH-1:0]    per_load_val;
  logic                       per_expired;
  logic                       wd_expired;

  assign start_ok    = (state_q == ST_IDLE) && start && !abort;
  assign in_wait     = (state_q == ST_WAIT_INPUT) || (state_q == ST_DRAIN);
  assign per_clamped = (tick_period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD)
                                                                 : tick_period;

  // The DRAIN->TICK decision is made one cycle before the pulse, so the timer is
  // reloaded with period-1 to land the next pulse exactly 'period' cycles later.
  // A fresh run loads zero so the first tick is not held back.
  assign per_load     = start_ok || (state_d == ST_TICK);
  assign per_load_val = start_ok ? '0 : per_q - 1'b1;

  ranc_period_timer #(.W(PERIOD_WIDTH)) u_period (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (per_load),
    .load_val (per_load_val),
    .en       (1'b1),
    .expired  (per_expired)
  );

  // Watchdog stays armed outside WAIT_INPUT/DRAIN and only counts while waiting;
  // it hits zero during the TIMEOUT_CYCLES-th waiting cycle.
  ranc_period_timer #(.W(WD_W)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (!in_wait),
    .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
    .en       (in_wait),
    .expired  (wd_expired)
  );

  // Next-state logic; abort overrides everything, including a pending stall.
  always_comb begin
    state_d   = state_q;
    stall_set = 1'b0;
    unique case (state_q)
      ST_IDLE:       if (start_ok) state_d = ST_WAIT_INPUT;
      ST_WAIT_INPUT: begin
        if (nt_q == '0)       state_d = ST_FINISH;
        else if (wd_expired) begin
          state_d   = ST_IDLE;
          stall_set = 1'b1;
        end
        else if (input_ready) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wd_expired) begin
          state_d   = ST_IDLE;
          stall_set = 1'b1;
        end
        else if (buffer_empty && per_expired) state_d = ST_TICK;
      end
      ST_TICK:   state_d = (tcnt_q == nt_q) ? ST_FINISH : ST_GAP;
      ST_GAP:    state_d = ST_WAIT_INPUT;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      stall_set = 1'b0;
    end
  end

  // Run parameters, counters and registered outputs.
  always_comb begin
    nt_d    = nt_q;
    per_d   = per_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    stall_d = stall_q;
    if (start_ok) begin
      nt_d    = num_ticks;
      per_d   = per_clamped;
      tcnt_d  = '0;
      scnt_d  = '0;
      stall_d = 1'b0;
    end
    if (state_d == ST_TICK) tcnt_d = tcnt_q + 1'b1;
    if (busy_q && packet_out_valid && !abort && scnt_q != '1) scnt_d = scnt_q + 1'b1;
    if (stall_set) stall_d = 1'b1;
    tick_d = (state_d == ST_TICK);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      nt_q    <= '0;
      per_q   <= PERIOD_WIDTH'(MIN_PERIOD);
      tcnt_q  <= '0;
      scnt_q  <= '0;
      stall_q <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nt_q    <= nt_d;
      per_q   <= per_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      stall_q <= stall_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tick        = tick_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tick_count  = tcnt_q;
  assign spike_count = scnt_q;
  assign stall_error = stall_q;

endmodule

// File: tb/tb_ranc_tick_scheduler.sv
// Bench for ranc_tick_scheduler: a run-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed cycle positions and counts.
module tb_ranc_tick_scheduler;

  localparam int TW   = 16;
  localparam int PW   = 20;
  localparam int SW   = 8;
  localparam int TO   = 100;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [TW-1:0] num_ticks = '0;
  logic [PW-1:0] tick_period = '0;
  logic          input_ready = 1'b0;
  logic          buffer_empty = 1'b0;
  logic          packet_out_valid = 1'b0;
  logic          tick, busy, done, stall_error;
  logic [TW-1:0] tick_count;
  logic [SW-1:0] spike_count;

  always #5 clk = ~clk;

  ranc_tick_scheduler #(
    .TICK_CNT_WIDTH  (TW),
    .PERIOD_WIDTH    (PW),
    .SPIKE_CNT_WIDTH (SW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .num_ticks        (num_ticks),
    .tick_period      (tick_period),
    .input_ready      (input_ready),
    .buffer_empty     (buffer_empty),
    .packet_out_valid (packet_out_valid),
    .tick             (tick),
    .busy             (busy),
    .done             (done),
    .tick_count       (tick_count),
    .spike_count      (spike_count),
    .stall_error      (stall_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected outputs for the cycle following each rising edge.
  logic e_tick = 0, e_busy = 0, e_done = 0, e_stall = 0;
  int   e_tcnt = 0, e_scnt = 0;
  int   m_cyc  = 0;

  // Advance one edge: sample inputs, count spikes seen while busy, drop pulses.
  task automatic adv(output bit ab, output bit st, output bit rdy, output bit emp);
    @(posedge clk);
    m_cyc++;
    ab  = abort;
    st  = start;
    rdy = input_ready;
    emp = buffer_empty;
    if (e_busy && packet_out_valid && !abort && e_scnt != SMAX) e_scnt++;
    e_tick = 0;
    e_done = 0;
    if (ab) e_busy = 0;
  endtask

  // One accepted run: for each tick, wait for staged input, then for an empty
  // buffer and the period since the previous pulse; give up after TO waiting cycles.
  task automatic run_model(input int nt, input int per);
    bit ab, st, rdy, emp, got;
    int waited, last;
    last = -1000000;
    if (nt == 0) begin
      adv(ab, st, rdy, emp);
      if (ab) return;
      e_done = 1;
      adv(ab, st, rdy, emp);
      e_busy = 0;
      return;
    end
    for (int k = 1; k <= nt; k++) begin
      waited = 0;
      got    = 0;
      forever begin
        adv(ab, st, rdy, emp);
        if (ab) return;
        waited++;
        if (waited == TO) begin
          e_stall = 1;
          e_busy  = 0;
          return;
        end
        if (!got) got = rdy;
        else if (emp && (m_cyc - last) >= per) break;
      end
      e_tick = 1;
      e_tcnt++;
      last = m_cyc;
      adv(ab, st, rdy, emp);
      if (ab) return;
      if (k == nt) begin
        e_done = 1;
        adv(ab, st, rdy, emp);
        e_busy = 0;
        return;
      end
      adv(ab, st, rdy, emp);
      if (ab) return;
    end
  endtask

  initial begin : model
    bit ab, st, rdy, emp;
    int nt, per;
    wait (rst_n === 1'b1);
    forever begin
      adv(ab, st, rdy, emp);
      if (!ab && st) begin
        e_busy  = 1;
        e_tcnt  = 0;
        e_scnt  = 0;
        e_stall = 0;
        nt      = int'(num_ticks);
        per     = (int'(tick_period) < 2) ? 2 : int'(tick_period);
        run_model(nt, per);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tick",        tick,        e_tick);
      chk("busy",        busy,        e_busy);
      chk("done",        done,        e_done);
      chk("tick_count",  tick_count,  e_tcnt);
      chk("spike_count", spike_count, e_scnt);
      chk("stall_error", stall_error, e_stall);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of cycle 1 of the run (start sampled by the edge before).
  task automatic pulse_start(input int nt, input int per);
    num_ticks   = TW'(nt);
    tick_period = PW'(per);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  initial begin : drive
    int tq[$];
    int done_at, bc, tc, dc, stall_at, busy100, busy101, busy9, tcnt9, sc101;
    int exp_t1[3];
    int exp_t5[2];
    exp_t1 = '{3, 13, 23};
    exp_t5 = '{3, 7};

    // Reset values
    cyc(2);
    chk("rst_tick",  tick, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_tcnt",  tick_count, 0);
    chk("rst_scnt",  spike_count, 0);
    chk("rst_stall", stall_error, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: three ticks, period 10, inputs always ready; a mid-run start is ignored
    input_ready  = 1'b1;
    buffer_empty = 1'b1;
    pulse_start(3, 10);
    done_at = 0;
    for (int k = 1; k <= 30; k++) begin
      if (tick) tq.push_back(k);
      if (done) done_at = k;
      if (k == 8) begin start = 1'b1; num_ticks = 7; end
      if (k == 9) start = 1'b0;
      @(negedge clk);
    end
    chk("t1_nticks", tq.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_tick_cyc", (i < tq.size()) ? tq[i] : -1, exp_t1[i]);
    chk("t1_done_cyc", done_at, 24);
    chk("t1_tick_count", tick_count, 3);
    chk("t1_busy_end", busy, 0);

    // 2: zero-length run
    pulse_start(0, 5);
    bc = 0; tc = 0; done_at = 0;
    for (int k = 1; k <= 10; k++) begin
      if (busy) bc++;
      if (tick) tc++;
      if (done) done_at = k;
      @(negedge clk);
    end
    chk("t2_busy_cycles", bc, 2);
    chk("t2_ticks", tc, 0);
    chk("t2_done_cyc", done_at, 2);

    // 3: buffer not empty for 50 cycles, period 4
    input_ready  = 1'b1;
    buffer_empty = 1'b0;
    pulse_start(1, 4);
    tc = 0;
    for (int k = 1; k <= 49; k++) begin
      if (tick) tc++;
      @(negedge clk);
    end
    buffer_empty = 1'b1;
    chk("t3_no_early_tick", tc + int'(tick), 0);
    @(negedge clk);
    chk("t3_tick_after_empty", tick, 1);
    chk("t3_no_stall", stall_error, 0);
    cyc(5);

    // 4: input never ready -> stall after TO waiting cycles
    input_ready = 1'b0;
    pulse_start(2, 4);
    stall_at = 0; dc = 0; busy100 = 0; busy101 = 1;
    for (int k = 1; k <= 120; k++) begin
      if (stall_error && stall_at == 0) stall_at = k;
      if (done) dc++;
      if (k == 100) busy100 = int'(busy);
      if (k == 101) busy101 = int'(busy);
      @(negedge clk);
    end
    chk("t4_stall_cyc", stall_at, 101);
    chk("t4_busy_at_100", busy100, 1);
    chk("t4_busy_at_101", busy101, 0);
    chk("t4_no_done", dc, 0);
    input_ready = 1'b1;
    pulse_start(1, 2);
    chk("t4_stall_cleared", stall_error, 0);
    cyc(10);

    // 5: abort in GAP after tick 2 of 5
    tq.delete();
    pulse_start(5, 4);
    dc = 0; busy9 = 1; tcnt9 = -1;
    for (int k = 1; k <= 30; k++) begin
      if (tick) tq.push_back(k);
      if (done) dc++;
      if (k == 9) begin busy9 = int'(busy); tcnt9 = int'(tick_count); end
      if (k == 8) abort = 1'b1;
      if (k == 9) abort = 1'b0;
      @(negedge clk);
    end
    chk("t5_nticks", tq.size(), 2);
    for (int i = 0; i < 2; i++) chk("t5_tick_cyc", (i < tq.size()) ? tq[i] : -1, exp_t5[i]);
    chk("t5_busy_after_abort", busy9, 0);
    chk("t5_tcnt_after_abort", tcnt9, 2);
    chk("t5_no_done", dc, 0);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t5b_start_dropped", busy, 0);
    cyc(3);

    // 6: spike counter saturation; idle pulses ignored
    packet_out_valid = 1'b1;
    cyc(5);
    packet_out_valid = 1'b0;
    chk("t6_idle_spikes", spike_count, 0);
    pulse_start(10, 40);
    packet_out_valid = 1'b1;
    sc101 = -1;
    for (int k = 1; k <= 300; k++) begin
      if (k == 101) sc101 = int'(spike_count);
      @(negedge clk);
    end
    packet_out_valid = 1'b0;
    chk("t6_spikes_at_101", sc101, 100);
    chk("t6_spikes_sat", spike_count, 255);
    chk("t6_busy_mid", busy, 1);
    cyc(80);
    chk("t6_run_over", busy, 0);
    chk("t6_tick_count", tick_count, 10);
    packet_out_valid = 1'b1;
    cyc(10);
    packet_out_valid = 1'b0;
    chk("t6_idle_spikes_after", spike_count, 255);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
